// File: rtl/bp_me_clint_initiator_pkg.sv
// Shared types for the CLINT initiator: register selector, BedRock header layout and
// the CLINT register offset map.
package bp_me_clint_initiator_pkg;

    localparam int paddr_width_lp   = 40;
    localparam int lce_id_width_lp  = 8;
    localparam int did_width_lp     = 3;
    localparam int core_id_width_lp = 4;

    localparam logic [19:0] mipi_reg_base_addr_lp     = 20'h0_0000;
    localparam logic [19:0] mtimecmp_reg_base_addr_lp = 20'h0_4000;
    localparam logic [19:0] mtimesel_reg_base_addr_lp = 20'h0_8000;
    localparam logic [19:0] plic_reg_base_addr_lp     = 20'h0_b000;
    localparam logic [19:0] mtime_reg_addr_lp         = 20'h0_bff8;
    localparam logic [19:0] debug_reg_base_addr_lp    = 20'h0_c000;

    typedef enum logic [2:0] {
        e_clint_mipi     = 3'd0,
        e_clint_mtimecmp = 3'd1,
        e_clint_mtimesel = 3'd2,
        e_clint_mtime    = 3'd3,
        e_clint_plic_m   = 3'd4,
        e_clint_plic_s   = 3'd5,
        e_clint_debug    = 3'd6
    } bp_clint_reg_e;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1 = 3'd0,
        e_bedrock_msg_size_2 = 3'd1,
        e_bedrock_msg_size_4 = 3'd2,
        e_bedrock_msg_size_8 = 3'd3
    } bp_bedrock_msg_size_e;

    typedef enum logic [1:0] {
        e_ready = 2'd0,
        e_send  = 2'd1,
        e_wait  = 2'd2,
        e_resp  = 2'd3
    } clint_init_state_e;

    typedef struct packed {
        logic [lce_id_width_lp-1:0] lce_id;
        logic [did_width_lp-1:0]    did;
    } bp_bedrock_mem_payload_s;

    typedef struct packed {
        bp_bedrock_mem_payload_s    payload;
        bp_bedrock_msg_size_e       size;
        logic [paddr_width_lp-1:0]  addr;
        bp_bedrock_mem_type_e       msg_type;
    } bp_bedrock_mem_header_s;

    // Device-local offset of each CLINT register; the supervisor PLIC bit sits one word above machine.
    function automatic logic [19:0] clint_reg_offset(input bp_clint_reg_e r);
        logic [19:0] off;
        case (r)
            e_clint_mipi:     off = mipi_reg_base_addr_lp;
            e_clint_mtimecmp: off = mtimecmp_reg_base_addr_lp;
            e_clint_mtimesel: off = mtimesel_reg_base_addr_lp;
            e_clint_mtime:    off = mtime_reg_addr_lp;
            e_clint_plic_m:   off = plic_reg_base_addr_lp;
            e_clint_plic_s:   off = plic_reg_base_addr_lp + 20'h0_0008;
            e_clint_debug:    off = debug_reg_base_addr_lp;
            default:          off = 20'h0_0000;
        endcase
        return off;
    endfunction

endpackage

// File: rtl/bp_me_clint_initiator.sv
// Single-outstanding initiator turning CLINT register commands into uncached BedRock
// messages and returning tag-checked responses, with a timeout on the reverse link.
module bp_me_clint_initiator
    import bp_me_clint_initiator_pkg::*;
#(
    parameter int core_offset_p        = 20,
    parameter int timeout_p            = 1024,
    parameter int bedrock_fill_width_p = 64,
    localparam int hdr_width_lp        = $bits(bp_bedrock_mem_header_s),
    localparam int timer_width_lp      = (timeout_p > 1) ? $clog2(timeout_p) : 1
)(
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [did_width_lp-1:0]         did_i,
    input  logic                            cmd_v_i,
    output logic                            cmd_ready_and_o,
    input  logic                            cmd_w_i,
    input  logic [2:0]                      cmd_reg_i,
    input  logic [core_id_width_lp-1:0]     cmd_core_i,
    input  logic [63:0]                     cmd_data_i,
    output logic                            resp_v_o,
    input  logic                            resp_ready_and_i,
    output logic [63:0]                     resp_data_o,
    output logic                            resp_err_o,
    output logic [hdr_width_lp-1:0]         mem_fwd_header_o,
    output logic [bedrock_fill_width_p-1:0] mem_fwd_data_o,
    output logic                            mem_fwd_v_o,
    input  logic                            mem_fwd_ready_and_i,
    input  logic [hdr_width_lp-1:0]         mem_rev_header_i,
    input  logic [bedrock_fill_width_p-1:0] mem_rev_data_i,
    input  logic                            mem_rev_v_i,
    output logic                            mem_rev_ready_and_o
);

    clint_init_state_e             r_state, w_state_next;
    logic [1:0]                    r_tag;
    logic [timer_width_lp-1:0]     r_timer;
    logic                          r_w;
    bp_clint_reg_e                 r_reg;
    logic [core_id_width_lp-1:0]   r_core;
    logic [63:0]                   r_data;
    logic [63:0]                   r_resp_data;
    logic                          r_resp_err;

    logic                          w_cmd_hs, w_fwd_hs, w_resp_hs, w_match, w_expire;
    bp_bedrock_mem_type_e          w_issued_type;
    bp_bedrock_mem_header_s        w_rev_hdr, w_fwd_hdr;
    logic [paddr_width_lp-1:0]     w_addr;

    assign w_cmd_hs      = cmd_v_i & (r_state == e_ready);
    assign w_fwd_hs      = (r_state == e_send) & mem_fwd_ready_and_i;
    assign w_resp_hs     = (r_state == e_resp) & resp_ready_and_i;
    assign w_issued_type = r_w ? e_bedrock_mem_uc_wr : e_bedrock_mem_uc_rd;
    assign w_rev_hdr     = bp_bedrock_mem_header_s'(mem_rev_header_i);
    // Stale beats from a timed-out transaction carry the previous tag and fall through here.
    assign w_match       = mem_rev_v_i & (r_state == e_wait)
                         & (w_rev_hdr.msg_type == w_issued_type)
                         & (w_rev_hdr.payload.lce_id[1:0] == r_tag);
    assign w_expire      = (r_timer == timer_width_lp'(timeout_p - 1));

    assign w_addr = (paddr_width_lp'(r_core) << core_offset_p)
                  | {{(paddr_width_lp-20){1'b0}}, clint_reg_offset(r_reg)};

    always_comb begin
        w_fwd_hdr                = '0;
        w_fwd_hdr.msg_type       = w_issued_type;
        w_fwd_hdr.addr           = w_addr;
        w_fwd_hdr.size           = e_bedrock_msg_size_8;
        w_fwd_hdr.payload.lce_id = {{(lce_id_width_lp-2){1'b0}}, r_tag};
        w_fwd_hdr.payload.did    = did_i;
    end

    assign mem_fwd_header_o    = w_fwd_hdr;
    assign mem_fwd_data_o      = r_w ? {(bedrock_fill_width_p/64){r_data}} : '0;
    assign mem_fwd_v_o         = (r_state == e_send);
    assign mem_rev_ready_and_o = 1'b1;
    assign cmd_ready_and_o     = (r_state == e_ready);
    assign resp_v_o            = (r_state == e_resp);
    assign resp_data_o         = r_resp_data;
    assign resp_err_o          = r_resp_err;

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) r_state <= e_ready;
        else            r_state <= w_state_next;
    end

    // FSM next-state logic; a match on the expiry cycle still completes without error.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            e_ready: if (w_cmd_hs)             w_state_next = e_send; else w_state_next = e_ready;
            e_send:  if (w_fwd_hs)             w_state_next = e_wait; else w_state_next = e_send;
            e_wait:  if (w_match || w_expire)  w_state_next = e_resp; else w_state_next = e_wait;
            e_resp:  if (w_resp_hs)            w_state_next = e_ready; else w_state_next = e_resp;
            default: w_state_next = e_ready;
        endcase
    end

    // Command capture.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_w    <= 1'b0;
            r_reg  <= e_clint_mipi;
            r_core <= '0;
            r_data <= 64'h0;
        end else if (w_cmd_hs) begin
            r_w    <= cmd_w_i;
            r_reg  <= bp_clint_reg_e'(cmd_reg_i);
            r_core <= cmd_core_i;
            r_data <= cmd_data_i;
        end
    end

    // Timeout counter: cleared on issue, advances only while waiting.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)               r_timer <= '0;
        else if (w_fwd_hs)            r_timer <= '0;
        else if (r_state == e_wait)   r_timer <= r_timer + timer_width_lp'(1);
        else                          r_timer <= r_timer;
    end

    // Response data/error registers and transaction tag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_resp_data <= 64'h0;
            r_resp_err  <= 1'b0;
            r_tag       <= 2'd0;
        end else if (w_match) begin
            r_resp_data <= r_w ? 64'h0 : mem_rev_data_i[63:0];
            r_resp_err  <= 1'b0;
        end else if ((r_state == e_wait) && w_expire) begin
            r_resp_data <= 64'h0;
            r_resp_err  <= 1'b1;
        end else if (w_resp_hs) begin
            r_resp_data <= 64'h0;
            r_resp_err  <= 1'b0;
            r_tag       <= r_tag + 2'd1;
        end
    end

endmodule

// File: tb/tb_bp_me_clint_initiator.sv
// Randomized bench for bp_me_clint_initiator with a CLINT register-file responder model.
module tb_bp_me_clint_initiator;
    import bp_me_clint_initiator_pkg::*;

    localparam int T    = 1024;
    localparam int HW   = $bits(bp_bedrock_mem_header_s);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  did;
    logic        cmd_v, cmd_ready, cmd_w;
    logic [2:0]  cmd_reg;
    logic [3:0]  cmd_core;
    logic [63:0] cmd_data;
    logic        resp_v, resp_ready, resp_err;
    logic [63:0] resp_data;
    logic [HW-1:0] fwd_hdr, rev_hdr;
    logic [63:0] fwd_data, rev_data;
    logic        fwd_v, fwd_ready, rev_v, rev_ready;

    always #5 clk = ~clk;

    bp_me_clint_initiator dut (
        .clk_i(clk), .reset_n_i(rst_n), .did_i(did),
        .cmd_v_i(cmd_v), .cmd_ready_and_o(cmd_ready), .cmd_w_i(cmd_w),
        .cmd_reg_i(cmd_reg), .cmd_core_i(cmd_core), .cmd_data_i(cmd_data),
        .resp_v_o(resp_v), .resp_ready_and_i(resp_ready),
        .resp_data_o(resp_data), .resp_err_o(resp_err),
        .mem_fwd_header_o(fwd_hdr), .mem_fwd_data_o(fwd_data),
        .mem_fwd_v_o(fwd_v), .mem_fwd_ready_and_i(fwd_ready),
        .mem_rev_header_i(rev_hdr), .mem_rev_data_i(rev_data),
        .mem_rev_v_i(rev_v), .mem_rev_ready_and_o(rev_ready)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state: CLINT register contents, expected tag, pending stale ack.
    logic [63:0] clint_mem [16][8];
    logic [19:0] offs [8];
    int          model_tag;
    bit          stale_pending;
    int          stale_tag;
    logic [3:0]  stale_type;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic send_rev(input logic [3:0] typ, input int tag, input logic [63:0] d);
        bp_bedrock_mem_header_s h;
        h = '0;
        h.msg_type = bp_bedrock_mem_type_e'(typ);
        h.payload.lce_id = 8'(tag & 3);
        rev_hdr  = h;
        rev_data = d;
        rev_v    = 1'b1;
        @(negedge clk);
        rev_v    = 1'b0;
    endtask

    // One command from issue to response consumption; mode 1 withholds the ack.
    task automatic txn(input bit w, input int rg, input int core, input logic [63:0] d,
                       input int stall, input int mode, input int junk);
        bp_bedrock_mem_header_s h;
        logic [3:0]  typ;
        logic [39:0] ea;
        logic [63:0] exp_d;
        int cnt;
        typ = w ? 4'd3 : 4'd2;
        ea  = (40'(core) << 20) | {20'h0, offs[rg]};
        check("cmd_ready_idle", cmd_ready, 1);
        did = 3'($urandom_range(0, 7));
        cmd_v = 1'b1; cmd_w = w; cmd_reg = 3'(rg); cmd_core = 4'(core); cmd_data = d;
        @(negedge clk);
        cmd_v = 1'b0; cmd_data = 64'($urandom);
        check("cmd_ready_busy", cmd_ready, 0);
        repeat (stall) @(negedge clk);
        h = fwd_hdr;
        check("fwd_v", fwd_v, 1);
        check("cmd_ready_send", cmd_ready, 0);
        check("fwd_type", 64'(h.msg_type), 64'(typ));
        check("fwd_addr", 64'(h.addr), 64'(ea));
        check("fwd_size", 64'(h.size), 64'd3);
        check("fwd_tag", 64'(h.payload.lce_id), 64'(model_tag));
        check("fwd_did", 64'(h.payload.did), 64'(did));
        check("fwd_data", fwd_data, w ? d : 64'h0);
        fwd_ready = 1'b1;
        @(negedge clk);
        fwd_ready = 1'b0;
        check("fwd_v_done", fwd_v, 0);
        exp_d = w ? 64'h0 : clint_mem[core][rg];
        if (w) clint_mem[core][rg] = d;
        if (mode == 1) begin
            cnt = 0;
            while (!resp_v && cnt < T + 10) begin
                @(negedge clk);
                cnt++;
            end
            check("timeout_cycles", 64'(cnt), 64'(T));
            check("timeout_err", resp_err, 1);
            check("timeout_data", resp_data, 64'h0);
            stale_pending = 1'b1; stale_tag = model_tag; stale_type = typ;
        end else begin
            if (stale_pending) begin
                send_rev(stale_type, stale_tag, 64'($urandom));
                stale_pending = 1'b0;
                check("stale_dropped", resp_v, 0);
            end
            if (junk == 1) begin
                send_rev(typ, model_tag ^ 1, 64'($urandom));
                check("wrong_tag_dropped", resp_v, 0);
            end else if (junk == 2) begin
                send_rev(w ? 4'd2 : 4'd3, model_tag, 64'($urandom));
                check("wrong_type_dropped", resp_v, 0);
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            check("no_early_resp", resp_v, 0);
            send_rev(typ, model_tag, w ? {$urandom, $urandom} : exp_d);
            check("resp_v", resp_v, 1);
            check("resp_err", resp_err, 0);
            check("resp_data", resp_data, exp_d);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("resp_hold_v", resp_v, 1);
        check("resp_hold_data", resp_data, mode == 1 ? 64'h0 : exp_d);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("resp_consumed", resp_v, 0);
        model_tag = (model_tag + 1) % 4;
    endtask

    initial begin
        offs = '{20'h0_0000, 20'h0_4000, 20'h0_8000, 20'h0_bff8,
                 20'h0_b000, 20'h0_b008, 20'h0_c000, 20'h0_0000};
        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 8; r++)
                clint_mem[c][r] = {$urandom, $urandom};
        model_tag = 0; stale_pending = 1'b0; stale_tag = 0; stale_type = 4'd0;
        rst_n = 1'b0; did = 3'd0; cmd_v = 1'b0; cmd_w = 1'b0; cmd_reg = 3'd0;
        cmd_core = 4'd0; cmd_data = 64'h0; resp_ready = 1'b0; fwd_ready = 1'b0;
        rev_hdr = '0; rev_data = 64'h0; rev_v = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fwd_v", fwd_v, 0);
        check("rst_resp_v", resp_v, 0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_resp_err", resp_err, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rev_ready", rev_ready, 1);

        txn(1'b1, 0, 2, 64'h1, 0, 0, 0);
        clint_mem[2][1] = 64'h1234;
        txn(1'b0, 1, 2, 64'h0, 5, 0, 0);
        txn(1'b0, 3, 7, 64'h0, 1, 1, 0);
        txn(1'b1, 4, 3, 64'hdead_beef, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            txn(1'b1, 5, i, 64'(i + 16), 0, 0, 0);
        for (int i = 0; i < 24; i++)
            txn(1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 15),
                {$urandom, $urandom}, $urandom_range(0, 5), 0, $urandom_range(0, 2));
        txn(1'b1, 6, 9, 64'h5, 0, 1, 0);
        txn(1'b0, 6, 9, 64'h0, 0, 0, 0);

        cmd_v = 1'b1; cmd_w = 1'b0; cmd_reg = 3'd3; cmd_core = 4'd1;
        @(negedge clk);
        cmd_v = 1'b0; fwd_ready = 1'b1;
        @(negedge clk);
        fwd_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_fwd_v", fwd_v, 0);
        check("midrst_resp_v", resp_v, 0);
        check("midrst_resp_data", resp_data, 64'h0);
        check("midrst_resp_err", resp_err, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_tag = 0; stale_pending = 1'b0;
        @(negedge clk);
        txn(1'b0, 1, 4, 64'h0, 2, 0, 0);
        txn(1'b1, 2, 4, 64'h77, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
